// File: rtl/fsm_state_reg_if.sv
// Bus between the next-state stage and the fsm_state_reg state register.
// The prev signal exists only when FSM_STATE_REG_HISTORY_EN is defined.
interface fsm_state_reg_if #(
   parameter int STATE_W = 4,
   parameter int CNT_W   = 8
);
   logic               en;
   logic [STATE_W-1:0] next;
   logic               clr;
   logic [STATE_W-1:0] a;
   logic               changed;
   logic [CNT_W-1:0]   dwell;
   logic [CNT_W-1:0]   wraps;
   logic               illegal;
`ifdef FSM_STATE_REG_HISTORY_EN
   logic [STATE_W-1:0] prev;
`endif

   modport master (
      output en, next, clr,
      input  a, changed, dwell, wraps, illegal
`ifdef FSM_STATE_REG_HISTORY_EN
      , input prev
`endif
   );

   modport slave (
      input  en, next, clr,
      output a, changed, dwell, wraps, illegal
`ifdef FSM_STATE_REG_HISTORY_EN
      , output prev
`endif
   );
endinterface

// File: rtl/fsm_state_reg.sv
// FSM state register with range check, change pulse, dwell/wrap counters.
// Optional FSM_STATE_REG_HISTORY_EN adds prev, the state held before the last change.
module fsm_state_reg #(
   parameter int NUM_STATES = 9,
   parameter int STATE_W    = 4,
   parameter int CNT_W      = 8
) (
   input logic            clk,
   input logic            rst_n,
   fsm_state_reg_if.slave bus
);

   localparam logic [STATE_W:0]   NUM_S = (STATE_W+1)'(NUM_STATES);
   localparam logic [STATE_W-1:0] LAST  = STATE_W'(NUM_STATES - 1);

   logic [STATE_W-1:0] a_q, a_d;
   logic               changed_q, changed_d;
   logic [CNT_W-1:0]   dwell_q, dwell_d;
   logic [CNT_W-1:0]   wraps_q, wraps_d;
   logic               illegal_q, illegal_d;
   logic               legal;
   logic               wrap_ev;
   logic               illegal_ev;
`ifdef FSM_STATE_REG_HISTORY_EN
   logic [STATE_W-1:0] prev_q, prev_d;
`endif

   always_comb begin
      legal      = ({1'b0, bus.next} < NUM_S);
      // Wraps count only genuine loads of 0 from the last state, never substitutions.
      wrap_ev    = bus.en && legal && (bus.next == '0) && (a_q == LAST);
      illegal_ev = bus.en && !legal;

      a_d = a_q;
      if (bus.en) begin
         a_d = legal ? bus.next : '0;
      end
      changed_d = (a_d != a_q);

      if (changed_d) begin
         dwell_d = '0;
      end else if (dwell_q == '1) begin
         dwell_d = dwell_q;
      end else begin
         dwell_d = dwell_q + CNT_W'(1);
      end

      wraps_d   = bus.clr ? '0 : wraps_q + CNT_W'(wrap_ev);
      illegal_d = bus.clr ? 1'b0 : (illegal_q | illegal_ev);

`ifdef FSM_STATE_REG_HISTORY_EN
      prev_d = changed_d ? a_q : prev_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         changed_q <= 1'b0;
         dwell_q   <= '0;
         wraps_q   <= '0;
         illegal_q <= 1'b0;
`ifdef FSM_STATE_REG_HISTORY_EN
         prev_q    <= '0;
`endif
      end else begin
         a_q       <= a_d;
         changed_q <= changed_d;
         dwell_q   <= dwell_d;
         wraps_q   <= wraps_d;
         illegal_q <= illegal_d;
`ifdef FSM_STATE_REG_HISTORY_EN
         prev_q    <= prev_d;
`endif
      end
   end

   assign bus.a       = a_q;
   assign bus.changed = changed_q;
   assign bus.dwell   = dwell_q;
   assign bus.wraps   = wraps_q;
   assign bus.illegal = illegal_q;
`ifdef FSM_STATE_REG_HISTORY_EN
   assign bus.prev    = prev_q;
`endif

endmodule

// File: tb/tb_fsm_state_reg.sv
// Self-checking bench for fsm_state_reg: directed scenarios plus randomized traffic
// against an integer reference model; prev is checked when FSM_STATE_REG_HISTORY_EN is defined.
module tb_fsm_state_reg;
   localparam int NS = 9;
   localparam int SW = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fsm_state_reg_if #(.STATE_W(SW), .CNT_W(CW)) bus ();

   fsm_state_reg #(.NUM_STATES(NS), .STATE_W(SW), .CNT_W(CW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: unbounded integers, limits applied only when read out.
   int m_a, m_dwell, m_wrapn, m_prev;
   bit m_ill, m_chg;

   function automatic int exp_dwell();
      return (m_dwell > 255) ? 255 : m_dwell;
   endfunction

   function automatic int exp_wraps();
      return m_wrapn % 256;
   endfunction

   task automatic model_reset();
      m_a = 0; m_dwell = 0; m_wrapn = 0; m_prev = 0; m_ill = 0; m_chg = 0;
   endtask

   // Apply one cycle of inputs, advance the model on the edge, settle 1 time unit.
   task automatic step(input bit e, input int nx, input bit c);
      int  tgt;
      bit  bad, wrap;
      bus.en   = e;
      bus.next = SW'(nx);
      bus.clr  = c;
      @(posedge clk);
      bad  = e && (nx >= NS);
      tgt  = !e ? m_a : (bad ? 0 : nx);
      wrap = e && !bad && (nx == 0) && (m_a == NS - 1);
      m_chg = (tgt != m_a);
      if (m_chg) begin
         m_prev  = m_a;
         m_dwell = 0;
      end else begin
         m_dwell++;
      end
      m_a     = tgt;
      m_wrapn = c ? 0 : m_wrapn + int'(wrap);
      m_ill   = c ? 1'b0 : (m_ill | bad);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (bus.a !== '0) begin errors++; $display("FAIL reset_a got %0d exp 0", bus.a); end
      checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %0b exp 0", bus.changed); end
      checks++; if (bus.dwell !== '0) begin errors++; $display("FAIL reset_dwell got %0d exp 0", bus.dwell); end
      checks++; if (bus.wraps !== '0) begin errors++; $display("FAIL reset_wraps got %0d exp 0", bus.wraps); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b exp 0", bus.illegal); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) step(1'b0, int'($urandom_range(0, 15)), 1'b0);
      checks++; if (bus.a !== '0) begin errors++; $display("FAIL idle_a got %0d exp 0", bus.a); end
      checks++; if (bus.dwell !== CW'(5)) begin errors++; $display("FAIL idle_dwell got %0d exp 5", bus.dwell); end
      checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL idle_changed got %0b exp 0", bus.changed); end
      checks++; if (bus.wraps !== '0) begin errors++; $display("FAIL idle_wraps got %0d exp 0", bus.wraps); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL idle_illegal got %0b exp 0", bus.illegal); end
   endtask

   task automatic test_walk();
      for (int i = 1; i <= NS; i++) begin
         step(1'b1, i % NS, 1'b0);
         checks++; if (bus.a !== SW'(i % NS)) begin errors++; $display("FAIL walk_a got %0d exp %0d", bus.a, i % NS); end
         checks++; if (bus.changed !== 1'b1) begin errors++; $display("FAIL walk_changed got %0b exp 1", bus.changed); end
         checks++; if (bus.dwell !== '0) begin errors++; $display("FAIL walk_dwell got %0d exp 0", bus.dwell); end
      end
      checks++; if (bus.wraps !== CW'(1)) begin errors++; $display("FAIL walk_wraps got %0d exp 1", bus.wraps); end
   endtask

   task automatic test_illegal();
      int w0;
      step(1'b1, 3, 1'b0);
      w0 = exp_wraps();
      step(1'b1, 12, 1'b0);
      checks++; if (bus.a !== '0) begin errors++; $display("FAIL illegal_a got %0d exp 0", bus.a); end
      checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %0b exp 1", bus.illegal); end
      checks++; if (bus.changed !== 1'b1) begin errors++; $display("FAIL illegal_changed got %0b exp 1", bus.changed); end
      checks++; if (bus.dwell !== '0) begin errors++; $display("FAIL illegal_dwell got %0d exp 0", bus.dwell); end
      checks++; if (bus.wraps !== CW'(w0)) begin errors++; $display("FAIL illegal_wraps got %0d exp %0d", bus.wraps, w0); end
      // Illegal from 8 is a substitution, not a wrap.
      step(1'b1, 8, 1'b0);
      step(1'b1, 15, 1'b0);
      checks++; if (bus.wraps !== CW'(w0)) begin errors++; $display("FAIL illegal_nowrap got %0d exp %0d", bus.wraps, w0); end
   endtask

   task automatic test_saturate();
      step(1'b1, 5, 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 5, 1'b0);
         checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL sat_changed cycle %0d got %0b exp 0", i, bus.changed); end
         checks++; if (bus.dwell !== CW'(exp_dwell())) begin errors++; $display("FAIL sat_dwell cycle %0d got %0d exp %0d", i, bus.dwell, exp_dwell()); end
      end
      checks++; if (bus.dwell !== CW'(255)) begin errors++; $display("FAIL sat_final got %0d exp 255", bus.dwell); end
   endtask

   task automatic test_clr();
      step(1'b1, 13, 1'b0);
      step(1'b1, 8, 1'b0);
      checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL clr_pending got %0b exp 1", bus.illegal); end
      step(1'b1, 0, 1'b1);
      checks++; if (bus.a !== '0) begin errors++; $display("FAIL clr_a got %0d exp 0", bus.a); end
      checks++; if (bus.wraps !== '0) begin errors++; $display("FAIL clr_wraps got %0d exp 0", bus.wraps); end
      checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL clr_illegal got %0b exp 0", bus.illegal); end
      checks++; if (bus.changed !== 1'b1) begin errors++; $display("FAIL clr_changed got %0b exp 1", bus.changed); end
   endtask

   task automatic test_async_reset();
      step(1'b1, 6, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, int'($urandom_range(0, 15)), 1'b0);
      checks++; if (bus.a !== SW'(6) || bus.dwell !== CW'(3)) begin errors++; $display("FAIL ar_setup got a=%0d dwell=%0d exp a=6 dwell=3", bus.a, bus.dwell); end
      @(negedge clk);
      bus.en = 1'b1; bus.next = SW'(2); bus.clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.a !== '0 || bus.dwell !== '0 || bus.changed !== 1'b0 || bus.wraps !== '0 || bus.illegal !== 1'b0) begin
         errors++; $display("FAIL ar_immediate got a=%0d dwell=%0d chg=%0b wraps=%0d ill=%0b exp all 0", bus.a, bus.dwell, bus.changed, bus.wraps, bus.illegal);
      end
`ifdef FSM_STATE_REG_HISTORY_EN
      checks++; if (bus.prev !== '0) begin errors++; $display("FAIL ar_prev got %0d exp 0", bus.prev); end
`endif
      @(posedge clk);
      #1;
      checks++; if (bus.a !== '0) begin errors++; $display("FAIL ar_inflight got %0d exp 0", bus.a); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 4, 1'b0);
      step(1'b1, 7, 1'b0);
      checks++; if (bus.a !== SW'(7)) begin errors++; $display("FAIL ar_walk got %0d exp 7", bus.a); end
`ifdef FSM_STATE_REG_HISTORY_EN
      checks++; if (bus.prev !== SW'(4)) begin errors++; $display("FAIL ar_walk_prev got %0d exp 4", bus.prev); end
      step(1'b1, 7, 1'b0);
      checks++; if (bus.prev !== SW'(4)) begin errors++; $display("FAIL prev_hold got %0d exp 4", bus.prev); end
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         int r, nx;
         bit e, c;
         r  = int'($urandom_range(0, 9));
         nx = (r < 5) ? (m_a + 1) % NS : (r < 7) ? m_a : int'($urandom_range(0, 15));
         e  = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 24) == 0);
         step(e, nx, c);
         checks++; if (bus.a !== SW'(m_a)) begin errors++; $display("FAIL rnd_a cycle %0d got %0d exp %0d", i, bus.a, m_a); end
         checks++; if (bus.changed !== m_chg) begin errors++; $display("FAIL rnd_changed cycle %0d got %0b exp %0b", i, bus.changed, m_chg); end
         checks++; if (bus.dwell !== CW'(exp_dwell())) begin errors++; $display("FAIL rnd_dwell cycle %0d got %0d exp %0d", i, bus.dwell, exp_dwell()); end
         checks++; if (bus.wraps !== CW'(exp_wraps())) begin errors++; $display("FAIL rnd_wraps cycle %0d got %0d exp %0d", i, bus.wraps, exp_wraps()); end
         checks++; if (bus.illegal !== m_ill) begin errors++; $display("FAIL rnd_illegal cycle %0d got %0b exp %0b", i, bus.illegal, m_ill); end
`ifdef FSM_STATE_REG_HISTORY_EN
         checks++; if (bus.prev !== SW'(m_prev)) begin errors++; $display("FAIL rnd_prev cycle %0d got %0d exp %0d", i, bus.prev, m_prev); end
`endif
      end
   endtask

   initial begin
      bus.en = 1'b0;
      bus.next = '0;
      bus.clr = 1'b0;
      model_reset();
      test_reset();
      test_walk();
      test_illegal();
      test_saturate();
      test_clr();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
